// File: rtl/array_unpacked_arbiter.sv
// Two-port round-robin access to one unpacked WA x WB array, self-filled with mem[a]=a after reset or init_req.
// Read data returns 1 cycle after grant; no response backpressure; rdy is held low during the fill.
module array_unpacked_arbiter #(
  parameter int WA = 8,
  parameter int WB = 8,
  localparam int AW = $clog2(WA)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          init_req,
  output logic          init_busy,
  input  logic          p0_vld,
  input  logic          p0_wen,
  input  logic [AW-1:0] p0_adr,
  input  logic [WB-1:0] p0_wdt,
  output logic          p0_rdy,
  output logic          p0_rsp_vld,
  output logic [WB-1:0] p0_rsp_rdt,
  output logic          p0_rsp_err,
  input  logic          p1_vld,
  input  logic          p1_wen,
  input  logic [AW-1:0] p1_adr,
  input  logic [WB-1:0] p1_wdt,
  output logic          p1_rdy,
  output logic          p1_rsp_vld,
  output logic [WB-1:0] p1_rsp_rdt,
  output logic          p1_rsp_err
);

  typedef enum logic {INIT, IDLE} state_t;

  localparam logic [AW-1:0] CNT_LAST = AW'(WA - 1);
  localparam int FW = (WB < AW) ? WB : AW;

  state_t        state, state_nxt;
  logic [AW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;
  logic          gnt0, gnt1, gnt;
  logic          acc_wen, adr_ok;
  logic [AW-1:0] acc_adr;
  logic [WB-1:0] acc_wdt, rd_dat, fill_val;
  logic [WB-1:0] mem [WA-1:0];

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    init_busy = (state == INIT);
    case (state)
      INIT: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      IDLE: begin
        // last=1 means port 1 won most recently, so port 0 takes the next tie
        gnt0 = p0_vld & (~p1_vld | last);
        gnt1 = p1_vld & (~p0_vld | ~last);
        if (init_req) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: state_nxt = INIT;
    endcase
  end

  assign gnt      = gnt0 | gnt1;
  assign last_nxt = gnt ? gnt1 : last;
  assign p0_rdy   = gnt0;
  assign p1_rdy   = gnt1;

  assign acc_wen = gnt1 ? p1_wen : p0_wen;
  assign acc_adr = gnt1 ? p1_adr : p0_adr;
  assign acc_wdt = gnt1 ? p1_wdt : p0_wdt;
  assign adr_ok  = (32'(acc_adr) < WA);
  assign rd_dat  = adr_ok ? mem[acc_adr] : '0;

  always_comb begin
    fill_val = '0;
    for (int i = 0; i < FW; i++) fill_val[i] = cnt[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      last  <= last_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p0_rsp_vld <= 1'b0;
      p0_rsp_rdt <= '0;
      p0_rsp_err <= 1'b0;
      p1_rsp_vld <= 1'b0;
      p1_rsp_rdt <= '0;
      p1_rsp_err <= 1'b0;
    end else begin
      p0_rsp_vld <= gnt0 & ~p0_wen;
      p1_rsp_vld <= gnt1 & ~p1_wen;
      if (gnt0 & ~p0_wen) begin
        p0_rsp_rdt <= rd_dat;
        p0_rsp_err <= ~adr_ok;
      end
      if (gnt1 & ~p1_wen) begin
        p1_rsp_rdt <= rd_dat;
        p1_rsp_err <= ~adr_ok;
      end
    end
  end

  // Storage is deliberately not reset; the fill sequence rewrites every word.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == INIT) mem[cnt] <= fill_val;
      else if (gnt && acc_wen && adr_ok) mem[acc_adr] <= acc_wdt;
    end
  end

endmodule

// File: tb/tb_array_unpacked_arbiter.sv
// Bench for array_unpacked_arbiter: an 8x8 instance and a 5x3 (non-power-of-two) instance.
module tb_array_unpacked_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic       a_rst, a_init_req, a_init_busy;
  logic       a_p0_vld, a_p0_wen, a_p0_rdy, a_p0_rsp_vld, a_p0_rsp_err;
  logic       a_p1_vld, a_p1_wen, a_p1_rdy, a_p1_rsp_vld, a_p1_rsp_err;
  logic [2:0] a_p0_adr, a_p1_adr;
  logic [7:0] a_p0_wdt, a_p1_wdt, a_p0_rsp_rdt, a_p1_rsp_rdt;

  logic       b_rst, b_init_req, b_init_busy;
  logic       b_p0_vld, b_p0_wen, b_p0_rdy, b_p0_rsp_vld, b_p0_rsp_err;
  logic       b_p1_vld, b_p1_wen, b_p1_rdy, b_p1_rsp_vld, b_p1_rsp_err;
  logic [2:0] b_p0_adr, b_p1_adr;
  logic [2:0] b_p0_wdt, b_p1_wdt, b_p0_rsp_rdt, b_p1_rsp_rdt;

  // Reference model: array contents and the port that won most recently.
  logic [7:0] ma [8];
  logic [2:0] mb [5];
  logic       last_a;

  array_unpacked_arbiter #(.WA(8), .WB(8)) dut_a (
    .clk(clk), .rst(a_rst), .init_req(a_init_req), .init_busy(a_init_busy),
    .p0_vld(a_p0_vld), .p0_wen(a_p0_wen), .p0_adr(a_p0_adr), .p0_wdt(a_p0_wdt), .p0_rdy(a_p0_rdy),
    .p0_rsp_vld(a_p0_rsp_vld), .p0_rsp_rdt(a_p0_rsp_rdt), .p0_rsp_err(a_p0_rsp_err),
    .p1_vld(a_p1_vld), .p1_wen(a_p1_wen), .p1_adr(a_p1_adr), .p1_wdt(a_p1_wdt), .p1_rdy(a_p1_rdy),
    .p1_rsp_vld(a_p1_rsp_vld), .p1_rsp_rdt(a_p1_rsp_rdt), .p1_rsp_err(a_p1_rsp_err)
  );

  array_unpacked_arbiter #(.WA(5), .WB(3)) dut_b (
    .clk(clk), .rst(b_rst), .init_req(b_init_req), .init_busy(b_init_busy),
    .p0_vld(b_p0_vld), .p0_wen(b_p0_wen), .p0_adr(b_p0_adr), .p0_wdt(b_p0_wdt), .p0_rdy(b_p0_rdy),
    .p0_rsp_vld(b_p0_rsp_vld), .p0_rsp_rdt(b_p0_rsp_rdt), .p0_rsp_err(b_p0_rsp_err),
    .p1_vld(b_p1_vld), .p1_wen(b_p1_wen), .p1_adr(b_p1_adr), .p1_wdt(b_p1_wdt), .p1_rdy(b_p1_rdy),
    .p1_rsp_vld(b_p1_rsp_vld), .p1_rsp_rdt(b_p1_rsp_rdt), .p1_rsp_err(b_p1_rsp_err)
  );

  function automatic void refill();
    for (int i = 0; i < 8; i++) ma[i] = 8'(i);
    for (int i = 0; i < 5; i++) mb[i] = 3'(i);
  endfunction

  // Counts init_busy cycles over a window starting at the negedge where rst was released.
  task automatic measure_fill(output int na, output int nb);
    na = 0;
    nb = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (a_init_busy) na++;
      if (b_init_busy) nb++;
      @(negedge clk);
    end
  endtask

  task automatic a_access(input int port, input logic wen, input logic [2:0] adr, input logic [7:0] wdt,
                          output int waited, output logic vld1, output logic [7:0] rdt,
                          output logic err, output logic vld2);
    @(negedge clk);
    if (port == 0) begin
      a_p0_vld = 1'b1; a_p0_wen = wen; a_p0_adr = adr; a_p0_wdt = wdt;
    end else begin
      a_p1_vld = 1'b1; a_p1_wen = wen; a_p1_adr = adr; a_p1_wdt = wdt;
    end
    waited = 0;
    #1;
    while ((port == 0 ? a_p0_rdy : a_p1_rdy) !== 1'b1 && waited < 40) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 40) waited = -1;
    else last_a = (port == 1);
    @(posedge clk); #1;
    a_p0_vld = 1'b0;
    a_p1_vld = 1'b0;
    @(negedge clk);
    vld1 = (port == 0) ? a_p0_rsp_vld : a_p1_rsp_vld;
    rdt  = (port == 0) ? a_p0_rsp_rdt : a_p1_rsp_rdt;
    err  = (port == 0) ? a_p0_rsp_err : a_p1_rsp_err;
    @(negedge clk);
    vld2 = (port == 0) ? a_p0_rsp_vld : a_p1_rsp_vld;
  endtask

  task automatic b_access(input logic wen, input logic [2:0] adr, input logic [2:0] wdt,
                          output int waited, output logic vld1, output logic [2:0] rdt,
                          output logic err, output logic vld2);
    @(negedge clk);
    b_p0_vld = 1'b1; b_p0_wen = wen; b_p0_adr = adr; b_p0_wdt = wdt;
    waited = 0;
    #1;
    while (b_p0_rdy !== 1'b1 && waited < 40) begin
      @(negedge clk); #1; waited++;
    end
    if (waited >= 40) waited = -1;
    @(posedge clk); #1;
    b_p0_vld = 1'b0;
    @(negedge clk);
    vld1 = b_p0_rsp_vld;
    rdt  = b_p0_rsp_rdt;
    err  = b_p0_rsp_err;
    @(negedge clk);
    vld2 = b_p0_rsp_vld;
  endtask

  task automatic test_reset();
    int na, nb;
    a_rst = 1'b1; b_rst = 1'b1; a_init_req = 1'b0; b_init_req = 1'b0;
    a_p0_vld = 1'b1; a_p0_wen = 1'b0; a_p0_adr = '0; a_p0_wdt = '0;
    a_p1_vld = 1'b1; a_p1_wen = 1'b0; a_p1_adr = '0; a_p1_wdt = '0;
    b_p0_vld = 1'b0; b_p0_wen = 1'b0; b_p0_adr = '0; b_p0_wdt = '0;
    b_p1_vld = 1'b0; b_p1_wen = 1'b0; b_p1_adr = '0; b_p1_wdt = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({a_init_busy, a_p0_rdy, a_p1_rdy, a_p0_rsp_vld, a_p1_rsp_vld, a_p0_rsp_err, a_p1_rsp_err,
         a_p0_rsp_rdt, a_p1_rsp_rdt} !== {1'b1, 22'h0}) begin
      errors++;
      $display("FAIL reset_a busy=%b rdy=%b%b vld=%b%b err=%b%b rdt=%h/%h want busy=1 all others 0",
               a_init_busy, a_p0_rdy, a_p1_rdy, a_p0_rsp_vld, a_p1_rsp_vld, a_p0_rsp_err, a_p1_rsp_err,
               a_p0_rsp_rdt, a_p1_rsp_rdt);
    end
    checks++;
    if ({b_init_busy, b_p0_rdy, b_p1_rdy, b_p0_rsp_vld, b_p1_rsp_vld, b_p0_rsp_err, b_p1_rsp_err,
         b_p0_rsp_rdt, b_p1_rsp_rdt} !== {1'b1, 12'h0}) begin
      errors++;
      $display("FAIL reset_b busy=%b rdy=%b%b vld=%b%b err=%b%b rdt=%h/%h want busy=1 all others 0",
               b_init_busy, b_p0_rdy, b_p1_rdy, b_p0_rsp_vld, b_p1_rsp_vld, b_p0_rsp_err, b_p1_rsp_err,
               b_p0_rsp_rdt, b_p1_rsp_rdt);
    end
    @(negedge clk);
    a_p0_vld = 1'b0; a_p1_vld = 1'b0;
    a_rst = 1'b0; b_rst = 1'b0;
    measure_fill(na, nb);
    checks++;
    if (na != 8) begin errors++; $display("FAIL fill_len_a got %0d want 8", na); end
    checks++;
    if (nb != 5) begin errors++; $display("FAIL fill_len_b got %0d want 5", nb); end
    refill();
    last_a = 1'b1;
  endtask

  task automatic test_reset_fill();
    int w; logic v1, v2, e; logic [7:0] r; logic [2:0] rb;
    for (int i = 0; i < 8; i++) begin
      a_access(0, 1'b0, 3'(i), 8'h00, w, v1, r, e, v2);
      checks++;
      if ({w == 0, v1, v2, e, r} !== {1'b1, 1'b1, 1'b0, 1'b0, ma[i]}) begin
        errors++;
        $display("FAIL fill_rd_a adr=%0d got wait=%0d vld=%b,%b err=%b rdt=%h want wait=0 vld=1,0 err=0 rdt=%h",
                 i, w, v1, v2, e, r, ma[i]);
      end
    end
    for (int i = 0; i < 5; i++) begin
      b_access(1'b0, 3'(i), 3'h0, w, v1, rb, e, v2);
      checks++;
      if ({w == 0, v1, v2, e, rb} !== {1'b1, 1'b1, 1'b0, 1'b0, mb[i]}) begin
        errors++;
        $display("FAIL fill_rd_b adr=%0d got wait=%0d vld=%b,%b err=%b rdt=%h want wait=0 vld=1,0 err=0 rdt=%h",
                 i, w, v1, v2, e, rb, mb[i]);
      end
    end
  endtask

  task automatic test_write_readback();
    int w; logic v1, v2, e; logic [7:0] r;
    a_access(0, 1'b1, 3'd3, 8'hA5, w, v1, r, e, v2);
    checks++;
    if ({w == 0, v1, v2} !== 3'b100) begin
      errors++;
      $display("FAIL wr_a got wait=%0d rsp_vld=%b,%b want wait=0 rsp_vld=0,0", w, v1, v2);
    end
    ma[3] = 8'hA5;
    for (int i = 3; i < 5; i++) begin
      a_access(0, 1'b0, 3'(i), 8'h00, w, v1, r, e, v2);
      checks++;
      if ({v1, e, r} !== {1'b1, 1'b0, ma[i]}) begin
        errors++;
        $display("FAIL rdback_a adr=%0d got vld=%b err=%b rdt=%h want vld=1 err=0 rdt=%h", i, v1, e, r, ma[i]);
      end
    end
  endtask

  task automatic test_contention();
    logic pend [2]; logic [7:0] pdat [2]; int g; int w; logic v1, v2, e; logic [7:0] r;
    pend[0] = 1'b0; pend[1] = 1'b0; pdat[0] = '0; pdat[1] = '0;
    @(negedge clk);
    a_p0_vld = 1'b1; a_p0_wen = 1'b0; a_p0_adr = 3'd1;
    a_p1_vld = 1'b1; a_p1_wen = 1'b0; a_p1_adr = 3'd6;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin a_p0_vld = 1'b0; a_p1_vld = 1'b0; end
      #1;
      g = (k == 4) ? -1 : (last_a ? 0 : 1);
      checks++;
      if ({a_p0_rdy, a_p1_rdy} !== {g == 0, g == 1}) begin
        errors++;
        $display("FAIL contend_rdy cyc=%0d got %b%b want %b%b", k, a_p0_rdy, a_p1_rdy, g == 0, g == 1);
      end
      checks++;
      if ({a_p0_rsp_vld, a_p1_rsp_vld} !== {pend[0], pend[1]}) begin
        errors++;
        $display("FAIL contend_rsp_vld cyc=%0d got %b%b want %b%b", k, a_p0_rsp_vld, a_p1_rsp_vld, pend[0], pend[1]);
      end
      if (pend[0] && a_p0_rsp_rdt !== pdat[0]) begin
        errors++; $display("FAIL contend_rdt0 cyc=%0d got %h want %h", k, a_p0_rsp_rdt, pdat[0]);
      end
      if (pend[1] && a_p1_rsp_rdt !== pdat[1]) begin
        errors++; $display("FAIL contend_rdt1 cyc=%0d got %h want %h", k, a_p1_rsp_rdt, pdat[1]);
      end
      if (pend[0] || pend[1]) checks++;
      pend[0] = (g == 0); pend[1] = (g == 1);
      if (g >= 0) begin
        pdat[g] = ma[(g == 0) ? 1 : 6];
        last_a = (g == 1);
      end
      @(negedge clk);
    end
    a_access(1, 1'b0, 3'd5, 8'h00, w, v1, r, e, v2);
    checks++;
    if ({w == 0, v1, r} !== {1'b1, 1'b1, ma[5]}) begin
      errors++;
      $display("FAIL lone_p1 got wait=%0d vld=%b rdt=%h want wait=0 vld=1 rdt=%h", w, v1, r, ma[5]);
    end
  endtask

  task automatic test_reinit();
    int w, n; logic v1, v2, e; logic [7:0] r;
    a_access(0, 1'b1, 3'd2, 8'hFF, w, v1, r, e, v2);
    ma[2] = 8'hFF;
    @(negedge clk);
    a_init_req = 1'b1;
    @(negedge clk);
    a_init_req = 1'b0;
    a_p1_vld = 1'b1; a_p1_wen = 1'b0; a_p1_adr = 3'd2;
    n = 0;
    #1;
    while (a_p1_rdy !== 1'b1 && n < 40) begin
      a_init_req = (n == 2);
      @(negedge clk); #1; n++;
    end
    a_init_req = 1'b0;
    checks++;
    if (n != 8 || a_init_busy !== 1'b0) begin
      errors++;
      $display("FAIL reinit_stall got %0d cycles busy=%b want 8 cycles busy=0", n, a_init_busy);
    end
    refill();
    last_a = 1'b1;
    @(posedge clk); #1;
    a_p1_vld = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_p1_rsp_vld, a_p1_rsp_rdt} !== {1'b1, ma[2]}) begin
      errors++;
      $display("FAIL reinit_rd got vld=%b rdt=%h want vld=1 rdt=%h", a_p1_rsp_vld, a_p1_rsp_rdt, ma[2]);
    end
  endtask

  task automatic test_nonpow2();
    int w; logic v1, v2, e; logic [2:0] r;
    b_access(1'b0, 3'd4, 3'h0, w, v1, r, e, v2);
    checks++;
    if ({v1, e, r} !== {1'b1, 1'b0, 3'b100}) begin
      errors++; $display("FAIL np2_rd4 got vld=%b err=%b rdt=%b want 1 0 100", v1, e, r);
    end
    b_access(1'b0, 3'd6, 3'h0, w, v1, r, e, v2);
    checks++;
    if ({w == 0, v1, e, r} !== {1'b1, 1'b1, 1'b1, 3'b000}) begin
      errors++; $display("FAIL np2_rd6 got wait=%0d vld=%b err=%b rdt=%b want wait=0 vld=1 err=1 rdt=000", w, v1, e, r);
    end
    b_access(1'b1, 3'd7, 3'b111, w, v1, r, e, v2);
    checks++;
    if ({w == 0, v1} !== 2'b10) begin
      errors++; $display("FAIL np2_wr7 got wait=%0d vld=%b want wait=0 vld=0", w, v1);
    end
    b_access(1'b1, 3'd1, 3'b110, w, v1, r, e, v2);
    mb[1] = 3'b110;
    for (int i = 0; i < 5; i++) begin
      b_access(1'b0, 3'(i), 3'h0, w, v1, r, e, v2);
      checks++;
      if ({v1, e, r} !== {1'b1, 1'b0, mb[i]}) begin
        errors++; $display("FAIL np2_scan adr=%0d got vld=%b err=%b rdt=%h want 1 0 %h", i, v1, e, r, mb[i]);
      end
    end
  endtask

  task automatic test_random();
    logic hold [2]; logic v [2]; logic w [2]; logic [2:0] ad [2]; logic [7:0] wd [2];
    logic pend [2]; logic [7:0] pdat [2]; int g;
    for (int p = 0; p < 2; p++) begin
      hold[p] = 1'b0; v[p] = 1'b0; w[p] = 1'b0; ad[p] = '0; wd[p] = '0; pend[p] = 1'b0; pdat[p] = '0;
    end
    @(negedge clk);
    for (int k = 0; k < 300; k++) begin
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          v[p]  = ($urandom_range(0, 9) < 7);
          w[p]  = $urandom_range(0, 1) == 1;
          ad[p] = 3'($urandom_range(0, 7));
          wd[p] = 8'($urandom);
        end
      end
      a_p0_vld = v[0]; a_p0_wen = w[0]; a_p0_adr = ad[0]; a_p0_wdt = wd[0];
      a_p1_vld = v[1]; a_p1_wen = w[1]; a_p1_adr = ad[1]; a_p1_wdt = wd[1];
      #1;
      if (v[0] && v[1]) g = last_a ? 0 : 1;
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
      else              g = -1;
      checks++;
      if ({a_p0_rdy, a_p1_rdy} !== {g == 0, g == 1}) begin
        errors++;
        $display("FAIL rand_rdy cyc=%0d got %b%b want %b%b", k, a_p0_rdy, a_p1_rdy, g == 0, g == 1);
      end
      checks++;
      if ({a_p0_rsp_vld, a_p1_rsp_vld} !== {pend[0], pend[1]}) begin
        errors++;
        $display("FAIL rand_rsp_vld cyc=%0d got %b%b want %b%b", k, a_p0_rsp_vld, a_p1_rsp_vld, pend[0], pend[1]);
      end
      if (pend[0] && {a_p0_rsp_err, a_p0_rsp_rdt} !== {1'b0, pdat[0]}) begin
        errors++; $display("FAIL rand_rdt0 cyc=%0d got err=%b rdt=%h want err=0 rdt=%h", k, a_p0_rsp_err, a_p0_rsp_rdt, pdat[0]);
      end
      if (pend[1] && {a_p1_rsp_err, a_p1_rsp_rdt} !== {1'b0, pdat[1]}) begin
        errors++; $display("FAIL rand_rdt1 cyc=%0d got err=%b rdt=%h want err=0 rdt=%h", k, a_p1_rsp_err, a_p1_rsp_rdt, pdat[1]);
      end
      if (pend[0] || pend[1]) checks++;
      pend[0] = 1'b0; pend[1] = 1'b0;
      if (g >= 0) begin
        if (w[g]) ma[ad[g]] = wd[g];
        else begin pend[g] = 1'b1; pdat[g] = ma[ad[g]]; end
        last_a = (g == 1);
      end
      for (int p = 0; p < 2; p++) hold[p] = v[p] && (g != p);
      @(negedge clk);
    end
    a_p0_vld = 1'b0; a_p1_vld = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    int na, nb, w; logic v1, v2, e; logic [2:0] r;
    @(negedge clk);
    a_p0_vld = 1'b1; a_p0_wen = 1'b0; a_p0_adr = 3'd0;
    #1;
    checks++;
    if (a_p0_rdy !== 1'b1) begin errors++; $display("FAIL ar_pre_grant got rdy=%b want 1", a_p0_rdy); end
    a_rst = 1'b1;
    #1;
    checks++;
    if ({a_p0_rsp_vld, a_p0_rdy, a_init_busy, a_p0_rsp_rdt} !== {3'b001, 8'h00}) begin
      errors++;
      $display("FAIL ar_in_rst got vld=%b rdy=%b busy=%b rdt=%h want 0 0 1 00", a_p0_rsp_vld, a_p0_rdy, a_init_busy, a_p0_rsp_rdt);
    end
    @(posedge clk); #1;
    checks++;
    if (a_p0_rsp_vld !== 1'b0) begin errors++; $display("FAIL ar_no_rsp got vld=%b want 0", a_p0_rsp_vld); end
    @(negedge clk);
    a_p0_vld = 1'b0; a_rst = 1'b0;
    measure_fill(na, nb);
    checks++;
    if (na != 8) begin errors++; $display("FAIL ar_fill_a got %0d want 8", na); end
    refill();
    last_a = 1'b1;
    @(negedge clk);
    a_p0_vld = 1'b1; a_p0_wen = 1'b0; a_p0_adr = 3'd3;
    a_p1_vld = 1'b1; a_p1_wen = 1'b0; a_p1_adr = 3'd5;
    #1;
    checks++;
    if ({a_p0_rdy, a_p1_rdy} !== 2'b10) begin errors++; $display("FAIL ar_first_tie got %b%b want 10", a_p0_rdy, a_p1_rdy); end
    @(negedge clk); #1;
    checks++;
    if ({a_p0_rdy, a_p1_rdy} !== 2'b01) begin errors++; $display("FAIL ar_second_tie got %b%b want 01", a_p0_rdy, a_p1_rdy); end
    @(posedge clk); #1;
    a_p0_vld = 1'b0; a_p1_vld = 1'b0;
    repeat (2) @(negedge clk);

    b_rst = 1'b1;
    @(negedge clk);
    b_rst = 1'b0;
    repeat (2) @(negedge clk);
    b_rst = 1'b1;
    #1;
    checks++;
    if (b_init_busy !== 1'b1) begin errors++; $display("FAIL ar_b_busy got %b want 1", b_init_busy); end
    @(negedge clk);
    b_rst = 1'b0;
    measure_fill(na, nb);
    checks++;
    if (nb != 5) begin errors++; $display("FAIL ar_fill_b got %0d want 5", nb); end
    refill();
    b_access(1'b0, 3'd1, 3'h0, w, v1, r, e, v2);
    checks++;
    if ({v1, r} !== {1'b1, mb[1]}) begin errors++; $display("FAIL ar_b_refill got vld=%b rdt=%h want 1 %h", v1, r, mb[1]); end

    @(negedge clk);
    b_p0_vld = 1'b1; b_p0_wen = 1'b0; b_p0_adr = 3'd3;
    @(posedge clk); #1;
    b_p0_vld = 1'b0;
    checks++;
    if ({b_p0_rsp_vld, b_p0_rsp_rdt} !== {1'b1, mb[3]}) begin
      errors++; $display("FAIL ar_b_rsp got vld=%b rdt=%h want 1 %h", b_p0_rsp_vld, b_p0_rsp_rdt, mb[3]);
    end
    b_rst = 1'b1;
    #1;
    checks++;
    if ({b_p0_rsp_vld, b_p0_rsp_err, b_p0_rsp_rdt} !== 5'b0) begin
      errors++; $display("FAIL ar_b_kill got vld=%b err=%b rdt=%h want 0 0 0", b_p0_rsp_vld, b_p0_rsp_err, b_p0_rsp_rdt);
    end
    @(negedge clk);
    b_rst = 1'b0;
    measure_fill(na, nb);
    checks++;
    if (nb != 5) begin errors++; $display("FAIL ar_fill_b2 got %0d want 5", nb); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_reset_fill();
    test_write_readback();
    test_contention();
    test_reinit();
    test_nonpow2();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
